rect_raster_writer: RTL and testbench

Parametrised rectangle rasteriser that replaces the single-shape chess/pointer painter feeding the VGA frame-buffer write port.
- Accepts one rectangle job per start/ready handshake.
- Walks every pixel in raster order, emitting coordinate, colour and a held write strobe.
- Supports fill, inscribed-disc and frame (outline) modes.
- Reports completion with a done pulse, so the board painter no longer needs worst-case countdown timers.

---
 rtl/rect_raster_writer_pkg.sv | 25 ++
 rtl/rect_raster_writer_shape.sv | 63 ++++++
 rtl/rect_raster_writer.sv | 168 ++++++++++++++++
 tb/tb_rect_raster_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rect_raster_writer_pkg.sv
// Shared mode codes, FSM encoding and default screen/colour widths for the rectangle rasteriser.
`default_nettype none

package rect_raster_writer_pkg;

   localparam int SCR_WIDTH_BITS  = 8;
   localparam int SCR_HEIGHT_BITS = 7;
   localparam int COLOR_SIZE      = 3;

   localparam logic [1:0] MODE_FILL  = 2'd0;
   localparam logic [1:0] MODE_DISC  = 2'd1;
   localparam logic [1:0] MODE_FRAME = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_STROBE = 3'd2,
      ST_GAP    = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rect_raster_writer_shape.sv
// rect_shape_test: combinational inside test for the current cursor against the latched job bounds.
`default_nettype none

module rect_shape_test
   import rect_raster_writer_pkg::*;
#(
   parameter int X_BITS = SCR_WIDTH_BITS,
   parameter int Y_BITS = SCR_HEIGHT_BITS
) (
   input  logic [1:0]        mode_i,
   input  logic [X_BITS-1:0] x_i,
   input  logic [X_BITS-1:0] x_start_i,
   input  logic [X_BITS-1:0] x_end_i,
   input  logic [X_BITS-1:0] x_last_i,
   input  logic [Y_BITS-1:0] y_i,
   input  logic [Y_BITS-1:0] y_start_i,
   input  logic [Y_BITS-1:0] y_end_i,
   input  logic [Y_BITS-1:0] y_last_i,
   output logic              inside_o
);

   localparam int M_BITS = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;
   localparam int P_BITS = 2 * M_BITS + 5;

   logic [X_BITS-1:0]        x_off, w, w_m1;
   logic [Y_BITS-1:0]        y_off, h, h_m1;
   logic [M_BITS-1:0]        w_m, h_m, r;
   logic signed [X_BITS+1:0] dx;
   logic signed [Y_BITS+1:0] dy;
   logic signed [P_BITS-1:0] dx_p, dy_p, dist_sq;
   logic [P_BITS-1:0]        r_p, r_sq;
   logic                     on_edge;

   // Doubled offsets from the centre keep the disc test exact for even and odd sizes.
   always_comb begin
      x_off   = x_i - x_start_i;
      y_off   = y_i - y_start_i;
      w       = x_end_i - x_start_i;
      h       = y_end_i - y_start_i;
      w_m1    = w - X_BITS'(1);
      h_m1    = h - Y_BITS'(1);
      dx      = $signed({1'b0, x_off, 1'b0}) - $signed({2'b00, w_m1});
      dy      = $signed({1'b0, y_off, 1'b0}) - $signed({2'b00, h_m1});
      dx_p    = {{(P_BITS-X_BITS-2){dx[X_BITS+1]}}, dx};
      dy_p    = {{(P_BITS-Y_BITS-2){dy[Y_BITS+1]}}, dy};
      w_m     = M_BITS'(w);
      h_m     = M_BITS'(h);
      r       = (w_m < h_m) ? w_m : h_m;
      r_p     = P_BITS'(r);
      r_sq    = r_p * r_p;
      dist_sq = dx_p * dx_p + dy_p * dy_p;
      on_edge = (x_i == x_start_i) || (x_i == x_last_i) ||
                (y_i == y_start_i) || (y_i == y_last_i);
      case (mode_i)
         MODE_DISC:  inside_o = ($unsigned(dist_sq) <= r_sq);
         MODE_FRAME: inside_o = on_edge;
         default:    inside_o = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rect_raster_writer.sv
// rect_raster_writer: walks a rectangle in raster order and issues held write strobes for the
// pixels selected by the fill/disc/frame shape test, ending each job with a done pulse.
`default_nettype none

module rect_raster_writer
   import rect_raster_writer_pkg::*;
#(
   parameter int X_BITS     = SCR_WIDTH_BITS,
   parameter int Y_BITS     = SCR_HEIGHT_BITS,
   parameter int COLOR_BITS = COLOR_SIZE,
   parameter int WE_HOLD    = 3
) (
   input  logic                     Clck,
   input  logic                     Reset,
   input  logic                     start,
   input  logic [X_BITS-1:0]        x_start,
   input  logic [X_BITS-1:0]        x_end,
   input  logic [Y_BITS-1:0]        y_start,
   input  logic [Y_BITS-1:0]        y_end,
   input  logic [1:0]               mode,
   input  logic [COLOR_BITS-1:0]    color,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [X_BITS-1:0]        paint_x_co,
   output logic [Y_BITS-1:0]        paint_y_co,
   output logic [COLOR_BITS-1:0]    color_output,
   output logic                     print_enable,
   output logic [X_BITS+Y_BITS-1:0] pixels_written
);

   localparam int PW_BITS = X_BITS + Y_BITS;

   state_t                 state_q;
   logic                   ready_q, busy_q, done_q, pe_q;
   logic [3:0]             hold_q;
   logic [X_BITS-1:0]      x_q, xs_q, xe_q, x_last_q;
   logic [Y_BITS-1:0]      y_q, ys_q, ye_q, y_last_q;
   logic [COLOR_BITS-1:0]  col_q;
   logic [1:0]             mode_q;
   logic [PW_BITS-1:0]     pw_q;
   logic                   degenerate_d, inside_d;

   assign degenerate_d = (x_end <= x_start) || (y_end <= y_start);

   rect_shape_test #(
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_shape (
      .mode_i    (mode_q),
      .x_i       (x_q),
      .x_start_i (xs_q),
      .x_end_i   (xe_q),
      .x_last_i  (x_last_q),
      .y_i       (y_q),
      .y_start_i (ys_q),
      .y_end_i   (ye_q),
      .y_last_i  (y_last_q),
      .inside_o  (inside_d)
   );

   always_ff @(posedge Clck) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pe_q     <= 1'b0;
         hold_q   <= 4'd0;
         x_q      <= '0;
         y_q      <= '0;
         col_q    <= '0;
         pw_q     <= '0;
         mode_q   <= MODE_FILL;
         xs_q     <= '0;
         xe_q     <= '0;
         x_last_q <= '0;
         ys_q     <= '0;
         ye_q     <= '0;
         y_last_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  pw_q    <= '0;
                  mode_q  <= mode;
                  xs_q    <= x_start;
                  xe_q    <= x_end;
                  ys_q    <= y_start;
                  ye_q    <= y_end;
                  if (degenerate_d) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     // The cursor doubles as the memory coordinate, so LOAD sees it immediately.
                     x_q      <= x_start;
                     y_q      <= y_start;
                     col_q    <= color;
                     x_last_q <= x_end - X_BITS'(1);
                     y_last_q <= y_end - Y_BITS'(1);
                     state_q  <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (inside_d) begin
                  pe_q    <= 1'b1;
                  hold_q  <= 4'(WE_HOLD - 1);
                  pw_q    <= pw_q + PW_BITS'(1);
                  state_q <= ST_STROBE;
               end else begin
                  state_q <= ST_NEXT;
               end
            end
            ST_STROBE: begin
               if (hold_q == 4'd0) begin
                  pe_q    <= 1'b0;
                  state_q <= ST_GAP;
               end else begin
                  hold_q <= hold_q - 4'd1;
               end
            end
            ST_GAP: begin
               state_q <= ST_NEXT;
            end
            ST_NEXT: begin
               if ((x_q == x_last_q) && (y_q == y_last_q)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (x_q == x_last_q) begin
                  x_q     <= xs_q;
                  y_q     <= y_q + Y_BITS'(1);
                  state_q <= ST_LOAD;
               end else begin
                  x_q     <= x_q + X_BITS'(1);
                  state_q <= ST_LOAD;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               pe_q    <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready          = ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign paint_x_co     = x_q;
   assign paint_y_co     = y_q;
   assign color_output   = col_q;
   assign print_enable   = pe_q;
   assign pixels_written = pw_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_raster_writer.sv
// Directed testbench for rect_raster_writer: fill/disc/frame jobs, degenerate job, held start, mid-job reset.
`default_nettype none

module tb_rect_raster_writer;

   localparam int XB = 8;
   localparam int YB = 7;
   localparam int CB = 3;
   localparam int WH = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [XB-1:0] x_start = '0, x_end = '0;
   logic [YB-1:0] y_start = '0, y_end = '0;
   logic [1:0]    mode = 2'd0;
   logic [CB-1:0] color = '0;
   logic          ready, busy, done, print_enable;
   logic [XB-1:0] paint_x_co;
   logic [YB-1:0] paint_y_co;
   logic [CB-1:0] color_output;
   logic [XB+YB-1:0] pixels_written;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations captured by run_job.
   logic [XB-1:0] rx [64];
   logic [YB-1:0] ry [64];
   logic [CB-1:0] rc [64];
   int n_str, done_cyc, first_cyc, hold_bad, gap_bad, coord_moved;

   rect_raster_writer #(
      .X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .WE_HOLD(WH)
   ) dut (
      .Clck(clk), .Reset(rst_n), .start(start),
      .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
      .mode(mode), .color(color),
      .ready(ready), .busy(busy), .done(done),
      .paint_x_co(paint_x_co), .paint_y_co(paint_y_co), .color_output(color_output),
      .print_enable(print_enable), .pixels_written(pixels_written)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 50 && !ready; k++) tick();
   endtask

   task automatic run_job(input logic [XB-1:0] xs, input logic [XB-1:0] xe,
                          input logic [YB-1:0] ys, input logic [YB-1:0] ye,
                          input logic [1:0] md, input logic [CB-1:0] col, input int budget);
      int hi, lo;
      logic prev;
      logic [XB-1:0] lx;
      logic [YB-1:0] ly;
      wait_ready();
      x_start = xs; x_end = xe; y_start = ys; y_end = ye; mode = md; color = col; start = 1'b1;
      tick();
      start = 1'b0;
      n_str = 0; done_cyc = -1; first_cyc = -1; hold_bad = 0; gap_bad = 0; coord_moved = 0;
      prev = 1'b0; hi = 0; lo = 0; lx = '0; ly = '0;
      for (int c = 1; c <= budget; c++) begin
         if (print_enable) begin
            if (!prev) begin
               if (n_str < 64) begin
                  rx[n_str] = paint_x_co; ry[n_str] = paint_y_co; rc[n_str] = color_output;
               end
               if (n_str > 0 && lo != 3) gap_bad++;
               if (n_str == 0) first_cyc = c;
               n_str++;
               hi = 0;
               lx = paint_x_co; ly = paint_y_co;
            end else if (paint_x_co !== lx || paint_y_co !== ly) begin
               coord_moved++;
            end
            hi++;
         end else begin
            if (prev) begin
               if (hi != WH) hold_bad++;
               lo = 0;
            end
            lo++;
         end
         prev = print_enable;
         if (done) begin
            done_cyc = c;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0 || print_enable !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: done=%b pe=%b want 0 0", done, print_enable); end
      n_checks++; if (paint_x_co !== 8'd0 || paint_y_co !== 7'd0 || color_output !== 3'd0) begin n_fail++; $display("FAIL reset_coords: got %0d,%0d,%0d want 0,0,0", paint_x_co, paint_y_co, color_output); end
      n_checks++; if (pixels_written !== 15'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", pixels_written); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      logic [XB-1:0] ex [4];
      logic [YB-1:0] ey [4];
      ex[0] = 8'd4; ex[1] = 8'd5; ex[2] = 8'd4; ex[3] = 8'd5;
      ey[0] = 7'd6; ey[1] = 7'd6; ey[2] = 7'd7; ey[3] = 7'd7;
      run_job(8'd4, 8'd6, 7'd6, 7'd8, 2'd0, 3'd5, 60);
      n_checks++; if (done_cyc !== 25) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want 25", done_cyc); end
      n_checks++; if (n_str !== 4) begin n_fail++; $display("FAIL fill_strobes: got %0d want 4", n_str); end
      n_checks++; if (first_cyc !== 2) begin n_fail++; $display("FAIL fill_first_strobe_cycle: got %0d want 2", first_cyc); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (rx[i] !== ex[i] || ry[i] !== ey[i] || rc[i] !== 3'd5) begin
            n_fail++; $display("FAIL fill_pixel%0d: got (%0d,%0d) c%0d want (%0d,%0d) c5", i, rx[i], ry[i], rc[i], ex[i], ey[i]);
         end
      end
      n_checks++; if (hold_bad !== 0) begin n_fail++; $display("FAIL fill_hold_len: got %0d bad strobes want 0", hold_bad); end
      n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL fill_gap_len: got %0d bad gaps want 0", gap_bad); end
      n_checks++; if (coord_moved !== 0) begin n_fail++; $display("FAIL fill_coord_stable: got %0d moves want 0", coord_moved); end
      n_checks++; if (pixels_written !== 15'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", pixels_written); end
      tick();
      n_checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL fill_after_done: ready=%b busy=%b done=%b want 1 0 0", ready, busy, done); end
   endtask

   task automatic test_disc();
      int corners;
      run_job(8'd0, 8'd4, 7'd0, 7'd4, 2'd1, 3'd3, 120);
      corners = 0;
      for (int i = 0; i < n_str && i < 64; i++)
         if ((rx[i] == 8'd0 || rx[i] == 8'd3) && (ry[i] == 7'd0 || ry[i] == 7'd3)) corners++;
      n_checks++; if (n_str !== 12) begin n_fail++; $display("FAIL disc_strobes: got %0d want 12", n_str); end
      n_checks++; if (corners !== 0) begin n_fail++; $display("FAIL disc_corners: got %0d want 0", corners); end
      n_checks++; if (pixels_written !== 15'd12) begin n_fail++; $display("FAIL disc_count: got %0d want 12", pixels_written); end
      n_checks++; if (done_cyc !== 81) begin n_fail++; $display("FAIL disc_done_cycle: got %0d want 81", done_cyc); end
      n_checks++; if (rx[0] !== 8'd1 || ry[0] !== 7'd0) begin n_fail++; $display("FAIL disc_first_pixel: got (%0d,%0d) want (1,0)", rx[0], ry[0]); end
   endtask

   task automatic test_frame();
      int hole;
      run_job(8'd10, 8'd13, 7'd10, 7'd13, 2'd2, 3'd7, 100);
      hole = 0;
      for (int i = 0; i < n_str && i < 64; i++)
         if (rx[i] == 8'd11 && ry[i] == 7'd11) hole++;
      n_checks++; if (n_str !== 8) begin n_fail++; $display("FAIL frame_strobes: got %0d want 8", n_str); end
      n_checks++; if (hole !== 0) begin n_fail++; $display("FAIL frame_centre: got %0d want 0", hole); end
      n_checks++; if (pixels_written !== 15'd8) begin n_fail++; $display("FAIL frame_count: got %0d want 8", pixels_written); end
      n_checks++; if (done_cyc !== 51) begin n_fail++; $display("FAIL frame_done_cycle: got %0d want 51", done_cyc); end
      n_checks++; if (rx[7] !== 8'd12 || ry[7] !== 7'd12) begin n_fail++; $display("FAIL frame_last_pixel: got (%0d,%0d) want (12,12)", rx[7], ry[7]); end
   endtask

   task automatic test_degenerate();
      run_job(8'd7, 8'd7, 7'd2, 7'd9, 2'd0, 3'd1, 20);
      n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL degen_done_cycle: got %0d want 1", done_cyc); end
      n_checks++; if (n_str !== 0) begin n_fail++; $display("FAIL degen_strobes: got %0d want 0", n_str); end
      n_checks++; if (pixels_written !== 15'd0) begin n_fail++; $display("FAIL degen_count: got %0d want 0", pixels_written); end
      n_checks++; if (paint_x_co !== 8'd12 || paint_y_co !== 7'd12 || color_output !== 3'd7) begin n_fail++; $display("FAIL degen_retain: got (%0d,%0d) c%0d want (12,12) c7", paint_x_co, paint_y_co, color_output); end
   endtask

   task automatic test_back_to_back();
      int rdy_cnt, rdy_first, done_cnt, done_at, str_cnt;
      logic prev, b21;
      logic [XB-1:0] x21;
      wait_ready();
      rdy_cnt = 0; rdy_first = -1; done_cnt = 0; done_at = -1; str_cnt = 0; prev = 1'b0; b21 = 1'b0; x21 = '1;
      x_start = 8'd0; x_end = 8'd3; y_start = 7'd0; y_end = 7'd1; mode = 2'd0; color = 3'd2; start = 1'b1;
      tick();
      for (int c = 1; c <= 38; c++) begin
         if (ready) begin rdy_cnt++; if (rdy_first < 0) rdy_first = c; end
         if (done) begin done_cnt++; done_at = c; end
         if (print_enable && !prev) str_cnt++;
         if (c == 21) begin b21 = busy; x21 = paint_x_co; end
         prev = print_enable;
         tick();
      end
      start = 1'b0;
      n_checks++; if (rdy_cnt !== 1 || rdy_first !== 20) begin n_fail++; $display("FAIL b2b_ready: got %0d highs first at %0d want 1 at 20", rdy_cnt, rdy_first); end
      n_checks++; if (done_cnt !== 1 || done_at !== 19) begin n_fail++; $display("FAIL b2b_done: got %0d pulses at %0d want 1 at 19", done_cnt, done_at); end
      n_checks++; if (str_cnt !== 6) begin n_fail++; $display("FAIL b2b_strobes: got %0d want 6", str_cnt); end
      n_checks++; if (b21 !== 1'b1 || x21 !== 8'd0) begin n_fail++; $display("FAIL b2b_restart: busy=%b x=%0d want 1 0", b21, x21); end
      for (int k = 0; k < 10 && !ready; k++) tick();
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_timeout: ready=%b want 1", ready); end
   endtask

   task automatic test_reset_mid_job();
      int rises;
      logic prev;
      wait_ready();
      rises = 0; prev = 1'b0;
      x_start = 8'd20; x_end = 8'd24; y_start = 7'd30; y_end = 7'd31; mode = 2'd0; color = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 40 && rises < 2; c++) begin
         if (print_enable && !prev) rises++;
         prev = print_enable;
         if (rises < 2) tick();
      end
      n_checks++; if (rises !== 2 || print_enable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach: got %0d strobes pe=%b want 2 1", rises, print_enable); end
      rst_n = 1'b0;
      tick();
      n_checks++; if (print_enable !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: pe=%b ready=%b busy=%b want 0 1 0", print_enable, ready, busy); end
      n_checks++; if (pixels_written !== 15'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", pixels_written); end
      rst_n = 1'b1;
      tick();
      run_job(8'd2, 8'd3, 7'd3, 7'd4, 2'd0, 3'd6, 30);
      n_checks++; if (n_str !== 1 || rx[0] !== 8'd2 || ry[0] !== 7'd3 || rc[0] !== 3'd6) begin n_fail++; $display("FAIL rst_mid_restart: got n=%0d (%0d,%0d) c%0d want n=1 (2,3) c6", n_str, rx[0], ry[0], rc[0]); end
      n_checks++; if (done_cyc !== 7 || pixels_written !== 15'd1) begin n_fail++; $display("FAIL rst_mid_restart_done: got cycle %0d count %0d want 7 1", done_cyc, pixels_written); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_disc();
      test_frame();
      test_degenerate();
      test_back_to_back();
      test_reset_mid_job();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
